onehot_seq_decoder: RTL and testbench

Parametrised, registered one-hot decoder with list sequencing for the register-file write/read enable path. In single mode it decodes an index to a one-hot enable, like the existing 4-to-16 decoder but registered and width-generic. In list mode it takes an ARM LDM/STM-style register mask and emits one one-hot enable per cycle for each set bit, in ascending or descending order. A stall input lets the memory stage hold the current beat.

---
 rtl/onehot_seq_decoder.sv | 211 +++++++++++++++++++++
 tb/tb_onehot_seq_decoder.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/onehot_seq_decoder.sv
// onehot_seq_decoder: registered one-hot decoder with LDM/STM-style list
// sequencing for the register-file enable path.
//   Single mode (i_mode=0): decodes i_sel to one registered one-hot beat.
//   List mode   (i_mode=1): walks the set bits of i_list one beat per cycle,
//                           lowest-first or highest-first (i_descending).
// Ports:
//   i_clk, i_rst_n          clock (rising edge), async active-low reset
//   i_start                 command strobe, accepted when not busy
//   i_mode, i_sel, i_list,  command payload, sampled on the accept cycle only
//   i_descending
//   i_stall                 holds the current beat while running
//   o_en, o_idx, o_valid    current beat (one-hot, binary index, valid)
//   o_last                  current beat is the final one of the command
//   o_busy, o_done          command running / one-cycle completion pulse
//   o_count                 beat count of the last accepted command
module onehot_seq_decoder #(
  parameter  int unsigned SEL_W = 4,
  localparam int unsigned N     = 1 << SEL_W,
  localparam int unsigned CNT_W = SEL_W + 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_mode,
  input  logic [SEL_W-1:0] i_sel,
  input  logic [N-1:0]     i_list,
  input  logic             i_descending,
  input  logic             i_stall,
  output logic [N-1:0]     o_en,
  output logic [SEL_W-1:0] o_idx,
  output logic             o_valid,
  output logic             o_last,
  output logic             o_busy,
  output logic             o_done,
  output logic [CNT_W-1:0] o_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [N-1:0]     mask_q, mask_d;
  logic             desc_q, desc_d;
  logic [N-1:0]     en_q, en_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [N-1:0]     new_mask;
  logic             new_desc;
  logic [N-1:0]     rem_mask;
  logic [N-1:0]     src_mask;
  logic             src_desc;
  logic [SEL_W-1:0] pick_idx;

  // Index of the lowest set bit (0 for an empty mask).
  function automatic logic [SEL_W-1:0] lsb_idx(input logic [N-1:0] m);
    logic [SEL_W-1:0] r;
    r = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (m[i]) r = SEL_W'(i);
    end
    return r;
  endfunction

  // Index of the highest set bit (0 for an empty mask).
  function automatic logic [SEL_W-1:0] msb_idx(input logic [N-1:0] m);
    logic [SEL_W-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      if (m[i]) r = SEL_W'(i);
    end
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] popcount(input logic [N-1:0] m);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < N; i++) begin
      c = c + CNT_W'(m[i]);
    end
    return c;
  endfunction

  function automatic logic single_bit(input logic [N-1:0] m);
    return (m != '0) && ((m & (m - N'(1))) == '0);
  endfunction

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      mask_q  <= '0;
      desc_q  <= 1'b0;
      en_q    <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      desc_q  <= desc_d;
      en_q    <= en_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      count_q <= count_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    desc_d  = desc_q;
    en_d    = en_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    last_d  = last_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    count_d = count_q;

    new_mask = i_mode ? i_list : (N'(1) << i_sel);
    new_desc = i_mode & i_descending;
    // Remaining work once the presented beat retires.
    rem_mask = mask_q & ~en_q;
    // The next beat comes from the fresh command mask when accepting, or
    // from what is left of the running mask otherwise.
    src_mask = (state_q == S_RUN) ? rem_mask : new_mask;
    src_desc = (state_q == S_RUN) ? desc_q : new_desc;
    pick_idx = src_desc ? msb_idx(src_mask) : lsb_idx(src_mask);

    case (state_q)
      S_RUN: begin
        if (!i_stall) begin
          if (last_q) begin
            state_d = S_DONE;
            mask_d  = '0;
            en_d    = '0;
            idx_d   = '0;
            valid_d = 1'b0;
            last_d  = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            mask_d  = rem_mask;
            en_d    = N'(1) << pick_idx;
            idx_d   = pick_idx;
            valid_d = 1'b1;
            last_d  = single_bit(src_mask);
            busy_d  = 1'b1;
          end
        end
      end
      default: begin
        // IDLE and DONE both accept a new command.
        if (i_start) begin
          desc_d  = new_desc;
          count_d = i_mode ? popcount(i_list) : CNT_W'(1);
          if (new_mask != '0) begin
            state_d = S_RUN;
            mask_d  = new_mask;
            en_d    = N'(1) << pick_idx;
            idx_d   = pick_idx;
            valid_d = 1'b1;
            last_d  = single_bit(src_mask);
            busy_d  = 1'b1;
          end else begin
            state_d = S_DONE;
            mask_d  = '0;
            en_d    = '0;
            idx_d   = '0;
            valid_d = 1'b0;
            last_d  = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
          mask_d  = '0;
          en_d    = '0;
          idx_d   = '0;
          valid_d = 1'b0;
          last_d  = 1'b0;
          busy_d  = 1'b0;
        end
      end
    endcase
  end

  assign o_en    = en_q;
  assign o_idx   = idx_q;
  assign o_valid = valid_q;
  assign o_last  = last_q;
  assign o_busy  = busy_q;
  assign o_done  = done_q;
  assign o_count = count_q;

endmodule

// File: tb/tb_onehot_seq_decoder.sv
// Testbench for onehot_seq_decoder: SEL_W=4 main instance plus SEL_W=3 and
// SEL_W=5 instances, checked against a queue-based beat-order model.
module tb_onehot_seq_decoder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // SEL_W = 4 instance
  logic        start = 1'b0, mode = 1'b0, desc = 1'b0, stall = 1'b0;
  logic [3:0]  sel = '0;
  logic [15:0] list = '0;
  logic [15:0] en;
  logic [3:0]  idx;
  logic        valid, last, busy, done;
  logic [4:0]  count;

  onehot_seq_decoder #(.SEL_W(4)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_mode(mode),
    .i_sel(sel), .i_list(list), .i_descending(desc), .i_stall(stall),
    .o_en(en), .o_idx(idx), .o_valid(valid), .o_last(last),
    .o_busy(busy), .o_done(done), .o_count(count)
  );

  // SEL_W = 3 and 5 instances (list mode, ascending, no stall)
  logic        p_mode = 1'b1, p_desc = 1'b0, p_stall = 1'b0;
  logic        s3_start = 1'b0, s5_start = 1'b0;
  logic [2:0]  s3_sel = '0;
  logic [4:0]  s5_sel = '0;
  logic [7:0]  s3_list = '0, s3_en;
  logic [31:0] s5_list = '0, s5_en;
  logic [2:0]  s3_idx;
  logic [4:0]  s5_idx;
  logic        s3_valid, s3_last, s3_busy, s3_done;
  logic        s5_valid, s5_last, s5_busy, s5_done;
  logic [3:0]  s3_count;
  logic [5:0]  s5_count;

  onehot_seq_decoder #(.SEL_W(3)) dut3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(s3_start), .i_mode(p_mode),
    .i_sel(s3_sel), .i_list(s3_list), .i_descending(p_desc), .i_stall(p_stall),
    .o_en(s3_en), .o_idx(s3_idx), .o_valid(s3_valid), .o_last(s3_last),
    .o_busy(s3_busy), .o_done(s3_done), .o_count(s3_count)
  );

  onehot_seq_decoder #(.SEL_W(5)) dut5 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(s5_start), .i_mode(p_mode),
    .i_sel(s5_sel), .i_list(s5_list), .i_descending(p_desc), .i_stall(p_stall),
    .o_en(s5_en), .o_idx(s5_idx), .o_valid(s5_valid), .o_last(s5_last),
    .o_busy(s5_busy), .o_done(s5_done), .o_count(s5_count)
  );

  int errors = 0;
  int checks = 0;
  int exp_q[$];
  int last_cnt = 0;

  // Reference order: set bits of the mask, ascending or reversed.
  task automatic build_exp(input logic [31:0] m, input int n, input bit d);
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      if (m[i]) begin
        if (d) exp_q.push_front(i);
        else   exp_q.push_back(i);
      end
    end
  endtask

  // Runs one SEL_W=4 command starting at the current negedge and ends in
  // the DONE cycle (at its negedge), so another call chains back-to-back.
  task automatic run_cmd(input bit m, input logic [3:0] s, input logic [15:0] l,
                         input bit d, input int stall_beat, input int stall_len,
                         input bit rnd_stall, input bit poke, input string name);
    logic [15:0] msk;
    logic [28:0] obs, expv;
    int cnt, k, left;
    msk = m ? l : (16'(1) << s);
    build_exp(32'(msk), 16, m ? d : 1'b0);
    cnt = exp_q.size();
    start = 1'b1; mode = m; sel = s; list = l; desc = d; stall = 1'b0;
    @(negedge clk);
    start = 1'b0; mode = 1'($urandom); sel = 4'($urandom);
    list = 16'($urandom); desc = 1'($urandom);
    k = 0; left = stall_len;
    while (k < cnt) begin
      obs  = {valid, idx, en, last, busy, done, count};
      expv = {1'b1, 4'(exp_q[k]), 16'(1) << exp_q[k], (k == cnt - 1), 1'b1, 1'b0, 5'(cnt)};
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL %s beat %0d: got %h want %h", name, k, obs, expv);
      end
      stall = 1'b0;
      if (k == stall_beat && left > 0) begin
        stall = 1'b1;
        left--;
      end else if (rnd_stall) begin
        stall = ($urandom_range(0, 2) == 0);
      end
      if (poke) begin
        start = 1'($urandom); mode = 1'($urandom);
        sel = 4'($urandom); list = 16'($urandom); desc = 1'($urandom);
      end
      if (!stall) k++;
      @(negedge clk);
    end
    start = 1'b0; stall = 1'b0;
    obs  = {valid, idx, en, last, busy, done, count};
    expv = {1'b0, 4'd0, 16'd0, 1'b0, 1'b0, 1'b1, 5'(cnt)};
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s done: got %h want %h", name, obs, expv);
    end
    last_cnt = cnt;
  endtask

  task automatic idle_check(input string name);
    logic [28:0] obs, expv;
    @(negedge clk);
    obs  = {valid, idx, en, last, busy, done, count};
    expv = {1'b0, 4'd0, 16'd0, 1'b0, 1'b0, 1'b0, 5'(last_cnt)};
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s idle: got %h want %h", name, obs, expv);
    end
  endtask

  task automatic test_reset();
    logic [28:0] obs;
    #2;
    obs = {valid, idx, en, last, busy, done, count};
    checks++;
    if (obs !== 29'd0) begin
      errors++;
      $display("FAIL reset: got %h want 0", obs);
    end
    @(negedge clk);
    rst_n = 1'b1;
    last_cnt = 0;
    idle_check("post_reset");
  endtask

  task automatic test_single();
    for (int s = 0; s < 16; s++) begin
      run_cmd(1'b0, 4'(s), 16'($urandom), 1'($urandom), -1, 0, 1'b0, 1'b0, "single");
      idle_check("single");
    end
  endtask

  task automatic test_list_asc();
    run_cmd(1'b1, 4'd0, 16'h8013, 1'b0, -1, 0, 1'b0, 1'b0, "list_asc");
    idle_check("list_asc");
  endtask

  task automatic test_desc_stall();
    run_cmd(1'b1, 4'd0, 16'h8013, 1'b1, 1, 2, 1'b0, 1'b0, "desc_stall");
    idle_check("desc_stall");
    run_cmd(1'b1, 4'd0, 16'h0024, 1'b0, 1, 3, 1'b0, 1'b0, "stall_last");
    idle_check("stall_last");
  endtask

  task automatic test_boundaries();
    run_cmd(1'b1, 4'd0, 16'h0000, 1'b0, -1, 0, 1'b0, 1'b0, "empty");
    idle_check("empty");
    run_cmd(1'b1, 4'd0, 16'hFFFF, 1'b0, -1, 0, 1'b0, 1'b0, "full_asc");
    idle_check("full_asc");
    run_cmd(1'b1, 4'd0, 16'hFFFF, 1'b1, -1, 0, 1'b0, 1'b0, "full_desc");
    idle_check("full_desc");
  endtask

  task automatic test_back_to_back();
    run_cmd(1'b1, 4'd0, 16'h0F0F, 1'b0, -1, 0, 1'b0, 1'b1, "b2b_a");
    run_cmd(1'b1, 4'd0, 16'hA005, 1'b1, -1, 0, 1'b0, 1'b1, "b2b_b");
    run_cmd(1'b1, 4'd0, 16'h0000, 1'b0, -1, 0, 1'b0, 1'b0, "b2b_empty");
    run_cmd(1'b0, 4'd7, 16'h1234, 1'b0, -1, 0, 1'b0, 1'b1, "b2b_single");
    idle_check("b2b");
  endtask

  task automatic test_random();
    for (int i = 0; i < 25; i++) begin
      run_cmd(1'($urandom), 4'($urandom), 16'($urandom), 1'($urandom),
              -1, 0, 1'b1, 1'b1, "random");
      if ($urandom_range(0, 1) == 0) idle_check("random");
    end
    idle_check("random_end");
  endtask

  task automatic test_async_reset();
    logic [28:0] obs;
    start = 1'b1; mode = 1'b1; list = 16'h00F0; desc = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (idx !== 4'd5 || valid !== 1'b1) begin
      errors++;
      $display("FAIL arst_beat2: got idx=%0d valid=%b want idx=5 valid=1", idx, valid);
    end
    rst_n = 1'b0;
    #1;
    obs = {valid, idx, en, last, busy, done, count};
    checks++;
    if (obs !== 29'd0) begin
      errors++;
      $display("FAIL arst_immediate: got %h want 0", obs);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      obs = {valid, idx, en, last, busy, done, count};
      checks++;
      if (obs !== 29'd0) begin
        errors++;
        $display("FAIL arst_hold: got %h want 0", obs);
      end
    end
    rst_n = 1'b1;
    last_cnt = 0;
    idle_check("arst_release");
    run_cmd(1'b1, 4'd0, 16'h00F0, 1'b0, -1, 0, 1'b0, 1'b0, "arst_fresh");
    idle_check("arst_fresh");
  endtask

  task automatic test_param_w3();
    logic [18:0] obs, expv;
    int cnt;
    for (int t = 0; t < 4; t++) begin
      s3_list = (t == 0) ? 8'h93 : 8'($urandom);
      build_exp(32'(s3_list), 8, 1'b0);
      cnt = exp_q.size();
      s3_start = 1'b1;
      @(negedge clk);
      s3_start = 1'b0; s3_list = 8'($urandom);
      for (int k = 0; k < cnt; k++) begin
        obs  = {s3_valid, s3_idx, s3_en, s3_last, s3_busy, s3_done, s3_count};
        expv = {1'b1, 3'(exp_q[k]), 8'(1) << exp_q[k], (k == cnt - 1), 1'b1, 1'b0, 4'(cnt)};
        checks++;
        if (obs !== expv) begin
          errors++;
          $display("FAIL w3 beat %0d: got %h want %h", k, obs, expv);
        end
        @(negedge clk);
      end
      obs  = {s3_valid, s3_idx, s3_en, s3_last, s3_busy, s3_done, s3_count};
      expv = {1'b0, 3'd0, 8'd0, 1'b0, 1'b0, 1'b1, 4'(cnt)};
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL w3 done: got %h want %h", obs, expv);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_param_w5();
    logic [46:0] obs, expv;
    int cnt;
    for (int t = 0; t < 4; t++) begin
      s5_list = (t == 0) ? 32'h8001_0013 : ((t == 1) ? 32'hFFFF_FFFF : 32'($urandom));
      build_exp(s5_list, 32, 1'b0);
      cnt = exp_q.size();
      s5_start = 1'b1;
      @(negedge clk);
      s5_start = 1'b0; s5_list = 32'($urandom);
      for (int k = 0; k < cnt; k++) begin
        obs  = {s5_valid, s5_idx, s5_en, s5_last, s5_busy, s5_done, s5_count};
        expv = {1'b1, 5'(exp_q[k]), 32'(1) << exp_q[k], (k == cnt - 1), 1'b1, 1'b0, 6'(cnt)};
        checks++;
        if (obs !== expv) begin
          errors++;
          $display("FAIL w5 beat %0d: got %h want %h", k, obs, expv);
        end
        @(negedge clk);
      end
      obs  = {s5_valid, s5_idx, s5_en, s5_last, s5_busy, s5_done, s5_count};
      expv = {1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1, 6'(cnt)};
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL w5 done: got %h want %h", obs, expv);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_list_asc();
    test_desc_stall();
    test_boundaries();
    test_back_to_back();
    test_random();
    test_async_reset();
    test_param_w3();
    test_param_w5();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
